// File: rtl/dt_repack_if.sv
// Bus bundle between the binary-image repacker and its surroundings:
// controller handshake (start/thresh/busy/done/fg_count), result-RAM read
// port (res_*), and image-RAM write port (sti_*).
interface dt_repack_if;
  logic        start;
  logic [7:0]  thresh;
  logic        busy;
  logic        done;
  logic        res_rd;
  logic [13:0] res_addr;
  logic [7:0]  res_di;
  logic        sti_wr;
  logic [9:0]  sti_addr;
  logic [15:0] sti_do;
  logic [14:0] fg_count;

  // Repacker side: issues reads and writes, reports status.
  modport master (
    input  start, thresh, res_di,
    output busy, done, res_rd, res_addr, sti_wr, sti_addr, sti_do, fg_count
  );

  // Controller / RAM side.
  modport slave (
    output start, thresh, res_di,
    input  busy, done, res_rd, res_addr, sti_wr, sti_addr, sti_do, fg_count
  );
endinterface

// File: rtl/dt_repack.sv
// Thresholds the 8-bit distance map (dist >= thresh -> 1), packs pixels MSB-first
// into 16-bit words for the binary-image RAM and counts foreground pixels.
// One pixel read per cycle; word w is written in cycle 16w+18; done in cycle 16*N_WORDS+3.
module dt_repack #(
  parameter int N_WORDS = 1024
) (
  input logic     clk,
  input logic     reset,
  dt_repack_if.master bus
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

  localparam logic [13:0] LAST_ADDR = 14'(16 * N_WORDS - 1);
  localparam logic [9:0]  LAST_WORD = 10'(N_WORDS - 1);

  state_t      state;
  logic [7:0]  thr;       // threshold captured at the accepted start
  logic [15:0] shreg;     // partially assembled word
  logic [3:0]  bcnt;      // pixels already in shreg
  logic [9:0]  wcnt;      // index of the word being assembled
  logic        rd_d;      // a read was issued last cycle, so res_di is valid now
  logic        pix;
  logic [15:0] word_nxt;

  // Threshold the returning pixel and form the word as it would look after capture.
  always_comb begin
    pix      = (bus.res_di >= thr);
    word_nxt = {shreg[14:0], pix};
  end

  // Control FSM plus read-address generation, pixel capture and word write-out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      thr          <= '0;
      shreg        <= '0;
      bcnt         <= '0;
      wcnt         <= '0;
      rd_d         <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.res_rd   <= 1'b0;
      bus.res_addr <= '0;
      bus.sti_wr   <= 1'b0;
      bus.sti_addr <= '0;
      bus.sti_do   <= '0;
      bus.fg_count <= '0;
    end else begin
      bus.sti_wr <= 1'b0;
      rd_d       <= bus.res_rd;

      // Capture one pixel per cycle whenever a read landed; every 16th completes a word.
      if (rd_d) begin
        shreg <= word_nxt;
        bcnt  <= bcnt + 4'd1;
        if (pix) begin
          bus.fg_count <= bus.fg_count + 15'd1;
        end
        if (bcnt == 4'd15) begin
          bus.sti_wr   <= 1'b1;
          bus.sti_addr <= wcnt;
          bus.sti_do   <= word_nxt;
          wcnt         <= wcnt + 10'd1;
        end
      end

      case (state)
        IDLE, FIN: begin
          // A new pass restarts all datapath state; pixel capture is idle here.
          if (bus.start) begin
            state        <= READ;
            thr          <= bus.thresh;
            shreg        <= '0;
            bcnt         <= '0;
            wcnt         <= '0;
            bus.fg_count <= '0;
            bus.done     <= 1'b0;
            bus.busy     <= 1'b1;
            bus.res_rd   <= 1'b1;
            bus.res_addr <= '0;
          end
        end
        READ: begin
          // Back-to-back reads; the address parks on the last pixel, never wraps.
          if (bus.res_addr == LAST_ADDR) begin
            bus.res_rd <= 1'b0;
            state      <= DRAIN;
          end else begin
            bus.res_addr <= bus.res_addr + 14'd1;
          end
        end
        DRAIN: begin
          // Finish once the final word's write strobe has been presented.
          if (bus.sti_wr && (bus.sti_addr == LAST_WORD)) begin
            state    <= FIN;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
